// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate-format codes, scheduler states.
// The immediate generator uses the same IMM_SEL_* codes.
package decode_issue_ctrl_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] IMM_SEL_NONE = 3'b000;
   localparam logic [2:0] IMM_SEL_I    = 3'b001;
   localparam logic [2:0] IMM_SEL_S    = 3'b010;
   localparam logic [2:0] IMM_SEL_B    = 3'b011;
   localparam logic [2:0] IMM_SEL_J    = 3'b100;
   localparam logic [2:0] IMM_SEL_U    = 3'b101;

   typedef enum logic {
      ST_RUN       = 1'b0,
      ST_LU_BUBBLE = 1'b1
   } state_t;

   function automatic logic [2:0] immSelOf(input logic [6:0] op);
      logic [2:0] sel;
      sel = IMM_SEL_NONE;
      case (op)
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: sel = IMM_SEL_I;
         OP_STORE:                            sel = IMM_SEL_S;
         OP_BRANCH:                           sel = IMM_SEL_B;
         OP_JAL:                              sel = IMM_SEL_J;
         OP_LUI, OP_AUIPC:                    sel = IMM_SEL_U;
         default:                             sel = IMM_SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch/execute-facing signal bundle of the decode-issue controller.
// slave is the controller side, master the pipeline/bench side.
interface decode_issue_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      instr_I;
   logic [31:0]      pc_I;
   logic             instrValid_I;
   logic             stallExt_I;
   logic             branchTaken_I;
   logic             exMemRead_I;
   logic [4:0]       exRd_I;
   logic [31:0]      instr_O;
   logic [31:0]      pc_O;
   logic             idValid_O;
   logic [2:0]       immSel_O;
   logic             fetchStall_O;
   logic             bubble_O;
   logic [CNT_W-1:0] stallCount_O;
   logic [CNT_W-1:0] flushCount_O;

   modport slave (
      input  instr_I, pc_I, instrValid_I, stallExt_I, branchTaken_I, exMemRead_I, exRd_I,
      output instr_O, pc_O, idValid_O, immSel_O, fetchStall_O, bubble_O,
             stallCount_O, flushCount_O
   );

   modport master (
      output instr_I, pc_I, instrValid_I, stallExt_I, branchTaken_I, exMemRead_I, exRd_I,
      input  instr_O, pc_O, idValid_O, immSel_O, fetchStall_O, bubble_O,
             stallCount_O, flushCount_O
   );
endinterface

// File: rtl/decode_issue_ctrl_hazard_detect.sv
// Load-use hazard: ID instruction reads a register that the load in EX is writing.
// Source-use decode keeps U/J formats and non-rs2 formats from false-matching garbage fields.
module hazard_detect
   import decode_issue_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   input  logic        idValid,
   input  logic        exMemRead,
   input  logic [4:0]  exRd,
   output logic        hazard
);
   logic [6:0] opcode;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       rs1Used;
   logic       rs2Used;

   assign opcode = instr[6:0];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   assign rs1Used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   assign rs2Used = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);

   assign hazard = idValid && exMemRead && (exRd != 5'd0) &&
                   ((rs1Used && rs1 == exRd) || (rs2Used && rs2 == exRd));
endmodule

// File: rtl/decode_issue_ctrl.sv
// IF/ID register and decode-stage scheduler: load-use bubble, branch flush, external freeze.
// Also keeps saturating debug counters of bubbles and flushes.
module decode_issue_ctrl
   import decode_issue_ctrl_pkg::*;
#(
   parameter int          CNT_W     = 16,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input logic                 clk_I,
   input logic                 rstn_I,
   decode_issue_ctrl_if.slave  bus
);
   state_t           state;
   logic [31:0]      idInstr;
   logic [31:0]      idPc;
   logic             idValid;
   logic             flushPending;
   logic [CNT_W-1:0] stallCount;
   logic [CNT_W-1:0] flushCount;
   logic             hazard;
   logic             flush;
   logic             luStall;

   hazard_detect uHazard (
      .instr     (idInstr),
      .idValid   (idValid),
      .exMemRead (bus.exMemRead_I),
      .exRd      (bus.exRd_I),
      .hazard    (hazard)
   );

   // A flush kills the ID instruction, so a hazard it carries no longer matters.
   assign flush   = bus.branchTaken_I | flushPending;
   assign luStall = !bus.stallExt_I && !flush && (state == ST_RUN) && hazard;

   always_ff @(posedge clk_I) begin
      if (!rstn_I) begin
         state        <= ST_RUN;
         idInstr      <= NOP_INSTR;
         idPc         <= 32'd0;
         idValid      <= 1'b0;
         flushPending <= 1'b0;
         stallCount   <= '0;
         flushCount   <= '0;
      end else if (bus.stallExt_I) begin
         // Remember a branch resolved during the freeze; apply it once the pipe moves.
         if (bus.branchTaken_I) flushPending <= 1'b1;
      end else if (flush) begin
         idInstr      <= NOP_INSTR;
         idValid      <= 1'b0;
         state        <= ST_RUN;
         flushPending <= 1'b0;
         if (~&flushCount) flushCount <= flushCount + 1'b1;
      end else if (luStall) begin
         state <= ST_LU_BUBBLE;
         if (~&stallCount) stallCount <= stallCount + 1'b1;
      end else begin
         // LU_BUBBLE lands here too: advance unconditionally so one load gives one bubble.
         idInstr <= bus.instr_I;
         idPc    <= bus.pc_I;
         idValid <= bus.instrValid_I;
         state   <= ST_RUN;
      end
   end

   assign bus.instr_O      = idInstr;
   assign bus.pc_O         = idPc;
   assign bus.idValid_O    = idValid;
   assign bus.immSel_O     = immSelOf(idInstr[6:0]);
   assign bus.fetchStall_O = bus.stallExt_I | luStall;
   assign bus.bubble_O     = luStall;
   assign bus.stallCount_O = stallCount;
   assign bus.flushCount_O = flushCount;
endmodule
